match_event_qualifier: RTL and testbench
========================================

// Module: match_event_qualifier
// PURPOSE
//   Downstream stage of the a/b/c/e pattern-match detector. Consumes its per-cycle
//   match flag (y) and auxiliary flag (d), and qualifies runs of consecutive matches.
//   Each run of at least MIN_RUN matches becomes an event record {length, d_seen}.
//   Records are buffered in a small FIFO and delivered over a valid/ready interface.
// PARAMETERS
//   MIN_RUN    3  minimum consecutive y=1 samples that form an event (>=1)
//   CNT_W      8  width of the run-length counter and of out_len
//   HOLDOFF    4  clock cycles in which samples are ignored after an event (0 = none)
//   FIFO_DEPTH 2  number of event records buffered (>=1)
// PORTS
//   clk        in   1      single clock; all logic is on the rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      y_in/d_in are sampled only when this is 1
//   y_in       in   1      match flag from the pattern detector
//   d_in       in   1      auxiliary flag from the pattern detector
//   out_valid  out  1      an event record is available
//   out_ready  in   1      the consumer accepts the record (transfer = valid & ready)
//   out_len    out  CNT_W  run length of the head record (saturated)
//   out_d      out  1      1 if d_in was 1 on any sample of the run
//   overflow   out  1      sticky: a record was dropped because the FIFO was full
//   busy       out  1      FSM not in IDLE, or FIFO not empty
// BEHAVIOUR
//   Reset: FSM=IDLE; counters cleared; FIFO empty; out_valid=0; out_len=0; out_d=0;
//     overflow=0; busy=0. A reset asserted mid-run or mid-holdoff aborts it without
//     pushing, and also clears the FIFO.
//   Cycles with in_valid=0: the FSM and run counters hold. The holdoff counter
//     still decrements on these cycles.
//   FSM states: IDLE, RUN, HOLD.
//   IDLE, on a valid sample:
//     y_in=1 -> RUN; run_cnt=1; d_acc=d_in.
//     y_in=0 -> stay in IDLE.
//   RUN, on a valid sample:
//     y_in=1 -> run_cnt+1, saturating at 2^CNT_W-1; d_acc |= d_in; stay in RUN.
//     y_in=0, run_cnt>=MIN_RUN -> push {run_cnt, d_acc}. Then go to HOLD, or to IDLE
//       if HOLDOFF=0.
//     y_in=0, run_cnt<MIN_RUN -> discard the run; go to IDLE.
//     The terminating y=0 sample never starts a new run.
//   HOLD: hold_cnt loads HOLDOFF on entry and decrements every clock. When it reaches
//     1, go to IDLE on the next edge, so exactly HOLDOFF cycles are ignored.
//     Samples (valid or not) are ignored while in HOLD.
//   Latency: a record is visible at the FIFO head (out_valid=1) on the first edge
//     after the terminating sample, if the FIFO was empty.
//   Handshake: while out_valid=1 and out_ready=0, out_len and out_d are held stable.
//     out_valid never drops without a transfer. With the FIFO empty: out_valid=0 and
//     out_len/out_d=0.
//   FIFO full with a push pending:
//     no pop in the same cycle -> drop the record; set overflow (sticky until rst).
//     pop in the same cycle -> the push is accepted; count is unchanged.
//   Push and pop in the same cycle with the FIFO not full: both take effect.
//   FIFO pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH+1).
// STRUCTURE
//   Shared package match_evt_pkg:
//     state enum {IDLE, RUN, HOLD};
//     record struct {logic [CNT_W-1:0] len; logic d};
//     IDLE encoding constant.
//   Sub-module match_evt_fifo: synchronous FIFO of records, parameterised by
//     DEPTH/width. Ports push, pop, full, empty, head; it owns the overflow flag.
//   The top level holds only the FSM and the run and holdoff counters.
// TESTING
//   1 y=1 for 3 valid samples, then y=0, d=0, out_ready=1
//     -> next cycle out_valid=1, out_len=3, out_d=0; busy=1 for 4 cycles of HOLD.
//   2 y=1 for 2 samples, then y=0
//     -> no record; FSM returns to IDLE; busy=0 one cycle later.
//   3 Run of 5 with d=1 on sample 4 only, and in_valid=0 gaps inside the run
//     -> a single record {len=5, d=1}.
//   4 CNT_W=4, run of 20 -> out_len=15 (saturated).
//   5 out_ready=0 and three qualifying runs (DEPTH=2)
//     -> records 1 and 2 held stable; 3rd dropped; overflow=1. Raise out_ready
//     -> records 1 then 2 drain; overflow stays 1.
//   6 rst pulsed mid-RUN with one record queued
//     -> next cycle out_valid=0, busy=0, overflow=0; a fresh run counts from 1.

Source files
------------

// File: rtl/match_evt_pkg.sv
// rtl/match_evt_pkg.sv - shared types for the match event qualifier
package match_evt_pkg;

    localparam logic [1:0] IDLE_ENC = 2'b00;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] len;
        logic                 d;
    } rec_t;

endpackage

// File: rtl/match_evt_fifo.sv
// rtl/match_evt_fifo.sv - record FIFO with sticky drop-on-full overflow flag
module match_evt_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic             overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/match_event_qualifier.sv
// rtl/match_event_qualifier.sv - qualifies runs of match flags into buffered event records
module match_event_qualifier
    import match_evt_pkg::*;
#(
    parameter int MIN_RUN    = 3,
    parameter int CNT_W      = 8,
    parameter int HOLDOFF    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             y_in,
    input  logic             d_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_len,
    output logic             out_d,
    output logic             overflow,
    output logic             busy
);
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [CNT_W-1:0]  MIN_LEN   = CNT_W'(MIN_RUN);

    state_t            state;
    logic [CNT_W-1:0]  run_cnt;
    logic              d_acc;
    logic [HOLD_W-1:0] hold_cnt;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;

    // The terminating sample pushes combinationally so the record lands on that same edge.
    assign push = in_valid && (state == RUN) && !y_in && (run_cnt >= MIN_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            run_cnt  <= '0;
            d_acc    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && y_in) begin
                        state   <= RUN;
                        run_cnt <= CNT_W'(1);
                        d_acc   <= d_in;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (y_in) begin
                            run_cnt <= (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);
                            d_acc   <= d_acc | d_in;
                        end else begin
                            run_cnt <= '0;
                            d_acc   <= 1'b0;
                            if (push && (HOLDOFF > 0)) begin
                                state    <= HOLD;
                                hold_cnt <= HOLD_LOAD;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    match_evt_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(CNT_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data({run_cnt, d_acc}),
        .pop      (out_ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     ({out_len, out_d}),
        .overflow (overflow)
    );

    assign out_valid = !fifo_empty;
    assign busy      = (state != IDLE) || !fifo_empty || fifo_full;

endmodule

// File: tb/tb_match_event_qualifier.sv
// tb/tb_match_event_qualifier.sv - directed self-checking bench for match_event_qualifier
module tb_match_event_qualifier;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       y_in = 1'b0;
    logic       d_in = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid, out_d, overflow, busy;
    logic [7:0] out_len;
    logic       out_valid4, out_d4, overflow4, busy4;
    logic [3:0] out_len4;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    match_event_qualifier dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in), .d_in(d_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_len(out_len),
        .out_d(out_d), .overflow(overflow), .busy(busy)
    );

    match_event_qualifier #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in), .d_in(d_in),
        .out_valid(out_valid4), .out_ready(out_ready), .out_len(out_len4),
        .out_d(out_d4), .overflow(overflow4), .busy(busy4)
    );

    task automatic sample(input logic v, input logic y, input logic d);
        in_valid = v;
        y_in     = y;
        d_in     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample(0, 0, 0);
        sample(0, 0, 0);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_len !== 8'd0) begin errors++; $display("FAIL reset_len got=%0d exp=0", out_len); end
        checks++; if (out_d !== 1'b0) begin errors++; $display("FAIL reset_d got=%0b exp=0", out_d); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_min_run();
        out_ready = 1'b1;
        repeat (3) sample(1, 1, 0);
        sample(1, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL min_run_valid got=%0b exp=1", out_valid); end
        checks++; if (out_len !== 8'd3) begin errors++; $display("FAIL min_run_len got=%0d exp=3", out_len); end
        checks++; if (out_d !== 1'b0) begin errors++; $display("FAIL min_run_d got=%0b exp=0", out_d); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL min_run_busy0 got=%0b exp=1", busy); end
        for (int k = 1; k <= 3; k++) begin
            sample(1, 1, 1);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy%0d got=%0b exp=1", k, busy); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_popped got=%0b exp=0", out_valid); end
        sample(1, 1, 1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_end_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_short_run();
        sample(1, 1, 0);
        sample(1, 1, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL short_busy_run got=%0b exp=1", busy); end
        sample(1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL short_valid got=%0b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_gaps();
        sample(1, 1, 0);
        sample(0, 0, 1);
        sample(1, 1, 0);
        sample(1, 1, 0);
        sample(0, 0, 0);
        sample(1, 1, 1);
        sample(1, 1, 0);
        sample(1, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid got=%0b exp=1", out_valid); end
        checks++; if (out_len !== 8'd5) begin errors++; $display("FAIL gaps_len got=%0d exp=5", out_len); end
        checks++; if (out_d !== 1'b1) begin errors++; $display("FAIL gaps_d got=%0b exp=1", out_d); end
        sample(1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gaps_single got=%0b exp=0", out_valid); end
        repeat (3) sample(1, 0, 0);
    endtask

    task automatic test_saturate();
        repeat (20) sample(1, 1, 0);
        sample(1, 0, 0);
        checks++; if (out_len !== 8'd20) begin errors++; $display("FAIL sat_len8 got=%0d exp=20", out_len); end
        checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL sat_valid4 got=%0b exp=1", out_valid4); end
        checks++; if (out_len4 !== 4'd15) begin errors++; $display("FAIL sat_len4 got=%0d exp=15", out_len4); end
        repeat (4) sample(1, 0, 0);
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        repeat (3) sample(1, 1, 0);
        sample(1, 0, 0);
        repeat (4) sample(1, 0, 0);
        sample(1, 1, 0);
        sample(1, 1, 1);
        sample(1, 1, 0);
        sample(1, 1, 0);
        sample(1, 0, 0);
        checks++; if (out_len !== 8'd3) begin errors++; $display("FAIL ovf_held_len got=%0d exp=3", out_len); end
        checks++; if (out_d !== 1'b0) begin errors++; $display("FAIL ovf_held_d got=%0b exp=0", out_d); end
        repeat (4) sample(1, 0, 0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%0b exp=0", overflow); end
        repeat (5) sample(1, 1, 0);
        sample(1, 0, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
        checks++; if (out_len !== 8'd3) begin errors++; $display("FAIL ovf_head_len got=%0d exp=3", out_len); end
        out_ready = 1'b1;
        sample(1, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain2_valid got=%0b exp=1", out_valid); end
        checks++; if (out_len !== 8'd4) begin errors++; $display("FAIL drain2_len got=%0d exp=4", out_len); end
        checks++; if (out_d !== 1'b1) begin errors++; $display("FAIL drain2_d got=%0b exp=1", out_d); end
        sample(1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
        repeat (2) sample(1, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b0;
        repeat (3) sample(1, 1, 0);
        sample(1, 0, 0);
        repeat (4) sample(1, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_queued got=%0b exp=1", out_valid); end
        sample(1, 1, 0);
        sample(1, 1, 0);
        rst = 1'b1;
        sample(1, 1, 0);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%0b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow got=%0b exp=0", overflow); end
        repeat (3) sample(1, 1, 0);
        sample(1, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fresh_valid got=%0b exp=1", out_valid); end
        checks++; if (out_len !== 8'd3) begin errors++; $display("FAIL fresh_len got=%0d exp=3", out_len); end
    endtask

    initial begin
        test_reset();
        test_min_run();
        test_short_run();
        test_gaps();
        test_saturate();
        test_overflow();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
